// File: rtl/stopwatch_timebase.sv
// rtl/stopwatch_timebase.sv - stopwatch prescaler, BCD time cascade and lap-freeze display
module stopwatch_timebase #(
   parameter int DIV     = 500000,
   parameter int DIV_W   = 23,
   parameter int MIN_MAX = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic       tick,
   output logic       running,
   output logic       overflow,
   output logic       lap_hold,
   output logic [7:0] disp_cs,
   output logic [7:0] disp_s,
   output logic [7:0] disp_m
);

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
   localparam logic [7:0]       M_LAST     = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

   logic [DIV_W-1:0] presc;
   logic             ss_q;
   logic             lap_q;
   logic [7:0]       live_cs;
   logic [7:0]       live_s;
   logic [7:0]       live_m;
   logic [7:0]       nxt_cs;
   logic [7:0]       nxt_s;
   logic [7:0]       nxt_m;
   logic             wrap;
   logic             ss_rise;
   logic             lap_rise;
   logic             term;

   // Packed-BCD increment of a two-digit value; the 99 case is handled by the caller.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   assign ss_rise  = start_stop & ~ss_q;
   assign lap_rise = lap & ~lap_q;
   assign term     = running && (presc == PRESC_LAST);

   // Next live time: centiseconds carry into seconds, seconds into minutes, minutes wrap.
   always_comb begin
      nxt_cs = bcd_inc(live_cs);
      nxt_s  = live_s;
      nxt_m  = live_m;
      wrap   = 1'b0;
      if (live_cs == 8'h99) begin
         nxt_cs = 8'h00;
         if (live_s == 8'h59) begin
            nxt_s = 8'h00;
            if (live_m == M_LAST) begin
               nxt_m = 8'h00;
               wrap  = 1'b1;
            end else begin
               nxt_m = bcd_inc(live_m);
            end
         end else begin
            nxt_s = bcd_inc(live_s);
         end
      end
   end

   // Button edge detectors and run/pause toggle; clear does not affect running.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ss_q    <= 1'b0;
         lap_q   <= 1'b0;
         running <= 1'b0;
      end else begin
         ss_q  <= start_stop;
         lap_q <= lap;
         if (ss_rise) begin
            running <= ~running;
         end
      end
   end

   // Prescaler, tick pulse, live time and sticky overflow; clear wins over a terminal count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc    <= '0;
         tick     <= 1'b0;
         live_cs  <= 8'h00;
         live_s   <= 8'h00;
         live_m   <= 8'h00;
         overflow <= 1'b0;
      end else if (clear) begin
         presc    <= '0;
         tick     <= 1'b0;
         live_cs  <= 8'h00;
         live_s   <= 8'h00;
         live_m   <= 8'h00;
         overflow <= 1'b0;
      end else if (term) begin
         presc   <= '0;
         tick    <= 1'b1;
         live_cs <= nxt_cs;
         live_s  <= nxt_s;
         live_m  <= nxt_m;
         if (wrap) begin
            overflow <= 1'b1;
         end
      end else begin
         tick <= 1'b0;
         if (running) begin
            presc <= presc + DIV_W'(1);
         end
      end
   end

   // Lap freeze toggle and display register, which tracks live time one cycle late unless frozen.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lap_hold <= 1'b0;
         disp_cs  <= 8'h00;
         disp_s   <= 8'h00;
         disp_m   <= 8'h00;
      end else begin
         if (clear) begin
            lap_hold <= 1'b0;
         end else if (lap_rise) begin
            lap_hold <= ~lap_hold;
         end
         if (!lap_hold) begin
            disp_cs <= live_cs;
            disp_s  <= live_s;
            disp_m  <= live_m;
         end
      end
   end

endmodule
